// File: rtl/spart_pkg.sv
// Shared definitions for the spart UART responder: bus register map,
// serial state encoding used by both the transmitter and the receiver,
// and default baud settings.
package spart_pkg;

   // ioaddr register map
   localparam logic [1:0] ADDR_BUF  = 2'b00;  // TX write / RX read buffer
   localparam logic [1:0] ADDR_STAT = 2'b01;  // {6'b0, tbr, rda}
   localparam logic [1:0] ADDR_DBL  = 2'b10;  // divisor low byte (write-only)
   localparam logic [1:0] ADDR_DBH  = 2'b11;  // divisor high byte (write-only)

   // 50 MHz / (16 * 19200) - 1
   localparam logic [15:0] DB_RESET_DEFAULT   = 16'd162;
   localparam int          OVERSAMPLE_DEFAULT = 16;

   // Frame phase, shared by the TX and RX state machines
   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } ser_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// Programmable baud tick generator: holds the 16-bit divisor and a down
// counter that pulses tick_o for one clk every DB+1 clks.
module spart_baud_gen
   import spart_pkg::*;
#(
   parameter logic [15:0] DB_RESET = DB_RESET_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       db_lo_we_i,
   input  logic       db_hi_we_i,
   input  logic [7:0] db_wdata_i,
   output logic       tick_o
);

   logic [15:0] db_q;
   logic [15:0] cnt_q, cnt_d;

   // Reload on zero; a divisor write only takes effect at the next reload.
   always_comb begin
      cnt_d = (cnt_q == 16'd0) ? db_q : cnt_q - 16'd1;
   end

   // Divisor bytes and down counter.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_q  <= DB_RESET;
         cnt_q <= DB_RESET;
      end else begin
         if (db_lo_we_i) db_q[7:0]  <= db_wdata_i;
         if (db_hi_we_i) db_q[15:8] <= db_wdata_i;
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = (cnt_q == 16'd0);

endmodule

// File: rtl/spart.sv
// spart: bus-side UART responder. Decodes the iocs/iorw/ioaddr/databus
// interface, serialises written bytes onto txd as 8N1 and deserialises
// rxd into a one-byte receive buffer, flagging rda/tbr to the driver.
module spart
   import spart_pkg::*;
#(
   parameter logic [15:0] DB_RESET   = DB_RESET_DEFAULT,
   parameter int          OVERSAMPLE = OVERSAMPLE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       iocs,
   input  logic       iorw,
   input  logic [1:0] ioaddr,
   inout  wire  [7:0] databus,
   output logic       rda,
   output logic       tbr,
   output logic       txd,
   input  logic       rxd
);

   localparam int             TW        = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [TW-1:0]  TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0]  HALF_LAST = TW'(OVERSAMPLE / 2 - 1);

   // ---------------- bus decode ----------------
   logic       bus_wr, bus_rd, buf_wr, buf_rd, drive_bus;
   logic [7:0] rd_data;
   logic       tick;

   assign bus_wr    = iocs & ~iorw;
   assign bus_rd    = iocs & iorw;
   assign buf_wr    = bus_wr && (ioaddr == ADDR_BUF);
   assign buf_rd    = bus_rd && (ioaddr == ADDR_BUF);
   assign drive_bus = bus_rd && ((ioaddr == ADDR_BUF) || (ioaddr == ADDR_STAT));

   // Divisor registers are write-only, so only buffer and status are ever driven.
   assign databus = drive_bus ? rd_data : 8'bz;

   spart_baud_gen #(
      .DB_RESET (DB_RESET)
   ) u_baud (
      .clk        (clk),
      .rst        (rst),
      .db_lo_we_i (bus_wr && (ioaddr == ADDR_DBL)),
      .db_hi_we_i (bus_wr && (ioaddr == ADDR_DBH)),
      .db_wdata_i (databus),
      .tick_o     (tick)
   );

   // ---------------- transmitter ----------------
   ser_state_t    tx_state_q, tx_state_d;
   logic [TW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          tbr_q, tbr_d;
   logic          txd_q, txd_d;

   // TX next state: accept a byte only while idle and ready, then walk the frame.
   // NOTE: every output of this block gets a default first; any path that
   // left one unassigned would infer a latch.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tbr_d      = tbr_q;
      case (tx_state_q)
         IDLE: begin
            if (tbr_q && buf_wr) begin
               tx_shift_d = databus;
               tbr_d      = 1'b0;
            end else if (!tbr_q && tick) begin
               tx_state_d = START;
               tx_cnt_d   = '0;
            end
         end
         START: begin
            if (tick) begin
               if (tx_cnt_q == TICK_LAST) begin
                  tx_state_d = DATA;
                  tx_cnt_d   = '0;
                  tx_bit_d   = '0;
               end else begin
                  tx_cnt_d = tx_cnt_q + TW'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (tx_cnt_q == TICK_LAST) begin
                  tx_cnt_d = '0;
                  if (tx_bit_q == 3'd7) begin
                     tx_state_d = STOP;
                  end else begin
                     tx_shift_d = {1'b0, tx_shift_q[7:1]};
                     tx_bit_d   = tx_bit_q + 3'd1;
                  end
               end else begin
                  tx_cnt_d = tx_cnt_q + TW'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (tx_cnt_q == TICK_LAST) begin
                  tx_state_d = IDLE;
                  tbr_d      = 1'b1;
               end else begin
                  tx_cnt_d = tx_cnt_q + TW'(1);
               end
            end
         end
      endcase
   end

   // Line level follows the next state so txd comes straight from a flop.
   always_comb begin
      case (tx_state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = tx_shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   // TX registers; reset forces the line idle and the buffer ready.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q <= IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tbr_q      <= 1'b1;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tbr_q      <= tbr_d;
         txd_q      <= txd_d;
      end
   end

   // ---------------- receiver ----------------
   logic          rx_meta_q, rx_sync_q;
   ser_state_t    rx_state_q, rx_state_d;
   logic [TW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_bit_q, rx_bit_d;
   logic [7:0]    rx_shift_q, rx_shift_d;
   logic [7:0]    rx_buf_q, rx_buf_d;
   logic          rda_q, rda_d;
   logic          rx_done;

   // RX next state: half-bit start qualification, then mid-bit sampling.
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;
      case (rx_state_q)
         IDLE: begin
            if (!rx_sync_q) begin
               rx_state_d = START;
               rx_cnt_d   = '0;
            end
         end
         START: begin
            if (tick) begin
               if (rx_cnt_q == HALF_LAST) begin
                  rx_cnt_d   = '0;
                  rx_bit_d   = '0;
                  rx_state_d = rx_sync_q ? IDLE : DATA;  // high here = glitch
               end else begin
                  rx_cnt_d = rx_cnt_q + TW'(1);
               end
            end
         end
         DATA: begin
            if (tick) begin
               if (rx_cnt_q == TICK_LAST) begin
                  rx_cnt_d   = '0;
                  rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_state_d = STOP;
                  else                  rx_bit_d   = rx_bit_q + 3'd1;
               end else begin
                  rx_cnt_d = rx_cnt_q + TW'(1);
               end
            end
         end
         STOP: begin
            if (tick) begin
               if (rx_cnt_q == TICK_LAST) begin
                  rx_state_d = IDLE;
                  rx_done    = rx_sync_q;  // low stop bit: framing error, drop byte
               end else begin
                  rx_cnt_d = rx_cnt_q + TW'(1);
               end
            end
         end
      endcase
   end

   // Receive buffer: a completing byte beats a simultaneous clearing read.
   always_comb begin
      rx_buf_d = rx_buf_q;
      rda_d    = rda_q;
      if (rx_done) begin
         rx_buf_d = rx_shift_q;
         rda_d    = 1'b1;
      end else if (buf_rd) begin
         rda_d = 1'b0;
      end
   end

   // RX registers, including the two-flop synchroniser for the async rxd.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_buf_q   <= '0;
         rda_q      <= 1'b0;
      end else begin
         rx_meta_q  <= rxd;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_buf_q   <= rx_buf_d;
         rda_q      <= rda_d;
      end
   end

   assign rd_data = (ioaddr == ADDR_STAT) ? {6'b0, tbr_q, rda_q} : rx_buf_q;
   assign rda     = rda_q;
   assign tbr     = tbr_q;
   assign txd     = txd_q;

endmodule

// File: tb/tb_spart.sv
// Self-checking bench for spart. The reference is a behavioural UART:
// frames are decoded from txd by sampling at bit centres computed from the
// divisor, rxd frames are generated the same way, and expected bytes are
// simply the bytes the bench chose.
module tb_spart;
   import spart_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       iocs = 1'b0;
   logic       iorw = 1'b1;
   logic [1:0] ioaddr = 2'b00;
   wire  [7:0] databus;
   logic [7:0] tb_dout = 8'h00;
   logic       tb_drive = 1'b0;
   logic       rda, tbr, txd;
   logic       rxd;
   logic       rxd_drv = 1'b1;
   logic       loop_en = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   assign databus = tb_drive ? tb_dout : 8'bz;
   assign rxd     = loop_en ? txd : rxd_drv;

   spart dut (
      .clk     (clk),
      .rst     (rst),
      .iocs    (iocs),
      .iorw    (iorw),
      .ioaddr  (ioaddr),
      .databus (databus),
      .rda     (rda),
      .tbr     (tbr),
      .txd     (txd),
      .rxd     (rxd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b0; ioaddr = a; tb_dout = d; tb_drive = 1'b1;
      @(negedge clk);
      iocs = 1'b0; iorw = 1'b1; tb_drive = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      iocs = 1'b1; iorw = 1'b1; ioaddr = a;
      #2 d = databus;
      @(negedge clk);
      iocs = 1'b0;
   endtask

   // The bench drives 0x00 itself; any DUT drive would disturb the value.
   task automatic probe_z(input string tag, input logic cs, input logic [1:0] a);
      logic [7:0] d;
      @(negedge clk);
      iocs = cs; iorw = 1'b1; ioaddr = a; tb_dout = 8'h00; tb_drive = 1'b1;
      #2 d = databus;
      check(tag, d, 8'h00);
      @(negedge clk);
      iocs = 1'b0; tb_drive = 1'b0;
   endtask

   task automatic set_db(input logic [15:0] db);
      bus_write(ADDR_DBL, db[7:0]);
      bus_write(ADDR_DBH, db[15:8]);
   endtask

   // Reference receiver on txd: bit period is 16*(DB+1) clk, sampled mid-bit;
   // tbr must rise exactly ten bit periods after the start edge.
   task automatic decode_tx(input string tag, input int db, input logic [7:0] exp_b);
      int p;
      int n;
      logic [7:0] b;
      p = 16 * (db + 1);
      n = 0;
      while (txd !== 1'b0 && n < 20 * p) begin @(negedge clk); n++; end
      check({tag, "_fall"}, txd, 0);
      repeat (p / 2) @(negedge clk);
      check({tag, "_start"}, txd, 0);
      for (int i = 0; i < 8; i++) begin
         repeat (p) @(negedge clk);
         b[i] = txd;
      end
      check({tag, "_data"}, b, exp_b);
      repeat (p) @(negedge clk);
      check({tag, "_stop"}, txd, 1);
      n = p / 2 + 9 * p;
      while (tbr !== 1'b1 && n < 10 * p + 100) begin @(negedge clk); n++; end
      check({tag, "_len"}, n, 10 * p);
   endtask

   // Reference transmitter onto rxd.
   task automatic drive_rx(input logic [7:0] b, input logic stop_bit, input int db);
      int p;
      p = 16 * (db + 1);
      @(negedge clk);
      rxd_drv = 1'b0;
      repeat (p) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd_drv = b[i];
         repeat (p) @(negedge clk);
      end
      rxd_drv = stop_bit;
      repeat (p) @(negedge clk);
      rxd_drv = 1'b1;
   endtask

   initial begin
      logic [7:0] rd;
      logic [7:0] b;
      int db;
      int lat;
      int zeros;

      // ---- reset state ----
      #1 rst = 1'b0;
      #21;
      check("rst_tbr", tbr, 1);
      check("rst_rda", rda, 0);
      check("rst_txd", txd, 1);
      @(negedge clk) rst = 1'b1;
      probe_z("z_idle_buf", 1'b0, ADDR_BUF);

      // ---- TX at DB=0 ----
      set_db(16'd0);
      repeat (170) @(negedge clk);
      bus_write(ADDR_BUF, 8'hA5);
      check("tx_a5_tbr_low", tbr, 0);
      decode_tx("tx_a5", 0, 8'hA5);

      // ---- TX at DB=3 ----
      set_db(16'd3);
      repeat (10) @(negedge clk);
      bus_write(ADDR_BUF, 8'h3C);
      check("tx_3c_tbr_low", tbr, 0);
      decode_tx("tx_3c", 3, 8'h3C);

      // ---- RX at DB=0 ----
      set_db(16'd0);
      repeat (10) @(negedge clk);
      drive_rx(8'h5A, 1'b1, 0);
      repeat (2) @(negedge clk);
      check("rx_5a_rda", rda, 1);
      bus_read(ADDR_BUF, rd);
      check("rx_5a_data", rd, 8'h5A);
      check("rx_5a_rda_clr", rda, 0);
      bus_read(ADDR_STAT, rd);
      check("stat_idle", rd, 8'h02);
      probe_z("z_nocs_stat", 1'b0, ADDR_STAT);
      probe_z("z_rd_dbl", 1'b1, ADDR_DBL);
      probe_z("z_rd_dbh", 1'b1, ADDR_DBH);

      // ---- false start and framing error ----
      @(negedge clk) rxd_drv = 1'b0;
      repeat (4) @(negedge clk);
      rxd_drv = 1'b1;
      repeat (200) @(negedge clk);
      check("false_start_rda", rda, 0);
      drive_rx(8'hC3, 1'b0, 0);
      repeat (100) @(negedge clk);
      check("frame_err_rda", rda, 0);
      drive_rx(8'h96, 1'b1, 0);
      repeat (2) @(negedge clk);
      check("rx_96_rda", rda, 1);
      bus_read(ADDR_BUF, rd);
      check("rx_96_data", rd, 8'h96);

      // ---- overrun and read-on-completion ----
      repeat (20) @(negedge clk);
      lat = 0;
      fork
         drive_rx(8'h11, 1'b1, 0);
         begin
            @(negedge clk);
            while (rda !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
         end
      join
      check("ovr_11_rda", rda, 1);
      repeat (20) @(negedge clk);
      drive_rx(8'h22, 1'b1, 0);
      repeat (2) @(negedge clk);
      check("ovr_22_rda", rda, 1);
      repeat (20) @(negedge clk);
      fork
         drive_rx(8'h33, 1'b1, 0);
         begin
            @(negedge clk);
            repeat (lat - 1) @(negedge clk);
            iocs = 1'b1; iorw = 1'b1; ioaddr = ADDR_BUF;
            #2 rd = databus;
            @(negedge clk);
            iocs = 1'b0;
         end
      join
      check("ovr_read_22", rd, 8'h22);
      check("coincide_rda", rda, 1);
      bus_read(ADDR_BUF, rd);
      check("coincide_data_33", rd, 8'h33);
      check("coincide_rda_clr", rda, 0);

      // ---- randomized loopback and direct RX frames ----
      for (int k = 0; k < 8; k++) begin
         db = int'($urandom_range(0, 3));
         b  = 8'($urandom);
         set_db(16'(db));
         repeat (10) @(negedge clk);
         if (k % 2 == 0) begin
            loop_en = 1'b1;
            bus_write(ADDR_BUF, b);
            decode_tx("rnd_tx", db, b);
            loop_en = 1'b0;
         end else begin
            drive_rx(b, 1'b1, db);
            repeat (4) @(negedge clk);
         end
         check("rnd_rda", rda, 1);
         bus_read(ADDR_BUF, rd);
         check("rnd_rx", rd, b);
         check("rnd_rda_clr", rda, 0);
      end

      // ---- write while busy is ignored ----
      set_db(16'd0);
      repeat (10) @(negedge clk);
      bus_write(ADDR_BUF, 8'h6B);
      fork
         decode_tx("tx_busy", 0, 8'h6B);
         begin
            repeat (40) @(negedge clk);
            bus_write(ADDR_BUF, 8'hFF);
         end
      join
      zeros = 0;
      repeat (300) begin
         @(negedge clk);
         if (txd === 1'b0) zeros++;
      end
      check("busy_no_2nd_frame", zeros, 0);
      check("busy_tbr_idle", tbr, 1);

      // ---- reset mid-frame (TX looped into RX) ----
      loop_en = 1'b1;
      bus_write(ADDR_BUF, 8'h81);
      repeat (50) @(negedge clk);
      check("mid_tx_line_low", txd, 0);
      #2 rst = 1'b0;
      #1;
      check("rst_mid_txd", txd, 1);
      check("rst_mid_tbr", tbr, 1);
      check("rst_mid_rda", rda, 0);
      @(negedge clk) rst = 1'b1;
      repeat (200) @(negedge clk);
      check("rst_partial_lost", rda, 0);

      // ---- divisor back at its reset value ----
      bus_write(ADDR_BUF, 8'h4E);
      decode_tx("tx_dbrst", 162, 8'h4E);
      check("dbrst_rx_rda", rda, 1);
      bus_read(ADDR_BUF, rd);
      check("dbrst_rx_data", rd, 8'h4E);
      loop_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
